// File: rtl/fifo_pkg.sv
// Shared constants for the write/read FIFO pointer controllers.
package fifo_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned PTR_W    = ADDR_W + 1;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned AFULL_TH = 12;

endpackage

// File: rtl/w_ctrl_if.sv
// Write-side FIFO control bundle: producer handshake, pointer exchange and status flags.
interface w_ctrl_if #(
    parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
);

    logic              w_en;
    logic [ADDR_W:0]   r_gaddr;
    logic              w_full;
    logic              w_afull;
    logic              w_overflow;
    logic [ADDR_W:0]   w_level;
    logic [ADDR_W:0]   w_addr;
    logic [ADDR_W:0]   w_gaddr;
    logic              ram_we;

    modport master (
        output w_en,
        output r_gaddr,
        input  w_full,
        input  w_afull,
        input  w_overflow,
        input  w_level,
        input  w_addr,
        input  w_gaddr,
        input  ram_we
    );

    modport slave (
        input  w_en,
        input  r_gaddr,
        output w_full,
        output w_afull,
        output w_overflow,
        output w_level,
        output w_addr,
        output w_gaddr,
        output ram_we
    );

endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter, shared by the write and read controllers.
module gray2bin
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = PTR_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/w_ctrl.sv
// Write-domain FIFO controller: binary/Gray write pointer, read-pointer synchronizer and flags.
module w_ctrl #(
    parameter int unsigned ADDR_W   = fifo_pkg::ADDR_W,
    parameter int unsigned AFULL_TH = fifo_pkg::AFULL_TH
) (
    input  logic    w_clk,
    input  logic    rst,
    w_ctrl_if.slave bus
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AfullLvl = PTR_W'(AFULL_TH);

    logic [PTR_W-1:0] addr_q;
    logic [PTR_W-1:0] gaddr_q;
    logic [PTR_W-1:0] d1_q;
    logic [PTR_W-1:0] d2_q;
    logic [PTR_W-1:0] level_q;
    logic             full_q;
    logic             afull_q;
    logic             ovf_q;

    logic             accept;
    logic [PTR_W-1:0] next;
    logic [PTR_W-1:0] gnext;
    logic [PTR_W-1:0] rbin_sync;
    logic [PTR_W-1:0] fill;
    logic [PTR_W-1:0] full_cmp;

    // Reset gating keeps the RAM strobe quiet while the pointers are held at zero.
    assign accept   = bus.w_en & ~full_q & ~rst;
    assign next     = addr_q + {{(PTR_W-1){1'b0}}, accept};
    assign gnext    = (next >> 1) ^ next;
    assign fill     = next - rbin_sync;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_cmp = {~d2_q[PTR_W-1:PTR_W-2], d2_q[PTR_W-3:0]};

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_gray2bin (
        .gray (d2_q),
        .bin  (rbin_sync)
    );

    always_ff @(posedge w_clk) begin
        if (rst) begin
            addr_q  <= '0;
            gaddr_q <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            d1_q    <= bus.r_gaddr;
            d2_q    <= d1_q;
            addr_q  <= next;
            gaddr_q <= gnext;
            full_q  <= (gnext == full_cmp);
            level_q <= fill;
            afull_q <= (fill >= AfullLvl);
            if (bus.w_en && full_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.ram_we     = accept;
    assign bus.w_addr     = addr_q;
    assign bus.w_gaddr    = gaddr_q;
    assign bus.w_full     = full_q;
    assign bus.w_afull    = afull_q;
    assign bus.w_overflow = ovf_q;
    assign bus.w_level    = level_q;

endmodule

// File: tb/tb_w_ctrl.sv
// Directed self-checking bench for the write-side FIFO controller.
module tb_w_ctrl;

    logic w_clk = 1'b0;
    logic rst   = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    w_ctrl_if #(.ADDR_W(4)) bus ();

    w_ctrl #(
        .ADDR_W   (4),
        .AFULL_TH (12)
    ) u_dut (
        .w_clk (w_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 w_clk = ~w_clk;

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        bus.w_en    = 1'b0;
        bus.r_gaddr = 5'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] rb;
        int         wcount;
        logic       full_seen;

        // Reset with w_en high and a nonzero read pointer.
        rst         = 1'b1;
        bus.w_en    = 1'b1;
        bus.r_gaddr = 5'b10101;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
            chk("rst_addr", 32'(bus.w_addr), 32'd0);
            chk("rst_gaddr", 32'(bus.w_gaddr), 32'd0);
            chk("rst_full", 32'(bus.w_full), 32'd0);
            chk("rst_afull", 32'(bus.w_afull), 32'd0);
            chk("rst_ovf", 32'(bus.w_overflow), 32'd0);
            chk("rst_level", 32'(bus.w_level), 32'd0);
        end
        rst         = 1'b0;
        bus.w_en    = 1'b0;
        bus.r_gaddr = 5'd0;
        #1;
        chk("post_rst_ram_we", 32'(bus.ram_we), 32'd0);
        tick();

        // Fill 16 entries with the reader parked at 0.
        for (int i = 0; i < 16; i++) begin
            bus.w_en = 1'b1;
            #1;
            chk("fill_ram_we", 32'(bus.ram_we), 32'd1);
            chk("fill_addr", 32'(bus.w_addr), 32'(i));
            tick();
            chk("fill_level", 32'(bus.w_level), 32'(i + 1));
            chk("fill_afull", 32'(bus.w_afull), (i + 1 >= 12) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(bus.w_full), (i == 15) ? 32'd1 : 32'd0);
        end
        chk("full_gaddr", 32'(bus.w_gaddr), 32'b11000);
        #1;
        chk("over_ram_we", 32'(bus.ram_we), 32'd0);
        tick();
        chk("over_ovf", 32'(bus.w_overflow), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("hold_addr", 32'(bus.w_addr), 32'd16);
        chk("hold_gaddr", 32'(bus.w_gaddr), 32'b11000);
        chk("hold_level", 32'(bus.w_level), 32'd16);

        // Release one slot.
        bus.w_en    = 1'b0;
        bus.r_gaddr = 5'b00001;
        tick();
        chk("rel_full_e1", 32'(bus.w_full), 32'd1);
        tick();
        chk("rel_full_e2", 32'(bus.w_full), 32'd1);
        tick();
        chk("rel_full_e3", 32'(bus.w_full), 32'd0);
        chk("rel_level", 32'(bus.w_level), 32'd15);
        chk("rel_afull", 32'(bus.w_afull), 32'd1);
        bus.w_en = 1'b1;
        #1;
        chk("rel_ram_we", 32'(bus.ram_we), 32'd1);
        chk("rel_addr", 32'(bus.w_addr), 32'd16);
        tick();
        bus.w_en = 1'b0;
        chk("rel_addr_after", 32'(bus.w_addr), 32'd17);
        chk("rel_refull", 32'(bus.w_full), 32'd1);
        chk("ovf_sticky", 32'(bus.w_overflow), 32'd1);

        // Write while full as the reader advances in the same cycle.
        do_reset();
        chk("sim_ovf_clear", 32'(bus.w_overflow), 32'd0);
        bus.w_en = 1'b1;
        repeat (16) tick();
        chk("sim_full", 32'(bus.w_full), 32'd1);
        bus.r_gaddr = 5'b00001;
        #1;
        chk("sim_ram_we", 32'(bus.ram_we), 32'd0);
        tick();
        bus.w_en = 1'b0;
        chk("sim_addr", 32'(bus.w_addr), 32'd16);
        chk("sim_gaddr", 32'(bus.w_gaddr), 32'b11000);
        chk("sim_ovf", 32'(bus.w_overflow), 32'd1);
        tick();
        chk("sim_full_e2", 32'(bus.w_full), 32'd1);
        tick();
        chk("sim_full_e3", 32'(bus.w_full), 32'd0);

        // Almost-full threshold crossing up and back down.
        do_reset();
        bus.w_en = 1'b1;
        repeat (11) tick();
        bus.w_en = 1'b0;
        chk("th_level11", 32'(bus.w_level), 32'd11);
        chk("th_afull11", 32'(bus.w_afull), 32'd0);
        bus.w_en = 1'b1;
        tick();
        bus.w_en = 1'b0;
        chk("th_level12", 32'(bus.w_level), 32'd12);
        chk("th_afull12", 32'(bus.w_afull), 32'd1);
        bus.r_gaddr = 5'b00001;
        tick();
        tick();
        chk("th_level_hold", 32'(bus.w_level), 32'd12);
        chk("th_afull_hold", 32'(bus.w_afull), 32'd1);
        tick();
        chk("th_level_down", 32'(bus.w_level), 32'd11);
        chk("th_afull_down", 32'(bus.w_afull), 32'd0);

        // 40 writes with a reader trailing two entries behind; pointer wraps.
        do_reset();
        rb        = 5'd0;
        wcount    = 0;
        full_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.w_en = 1'b1;
            #1;
            chk("wrap_ram_we", 32'(bus.ram_we), 32'd1);
            tick();
            wcount++;
            full_seen = full_seen | bus.w_full;
            if (wcount == 31) chk("wrap_gaddr31", 32'(bus.w_gaddr), 32'b10000);
            if (wcount == 32) begin
                chk("wrap_addr0", 32'(bus.w_addr), 32'd0);
                chk("wrap_gaddr0", 32'(bus.w_gaddr), 32'b00000);
            end
            if (5'(wcount) - rb > 5'd2) rb = 5'(wcount) - 5'd2;
            bus.r_gaddr = to_gray(rb);
        end
        bus.w_en = 1'b0;
        chk("wrap_no_full", 32'(full_seen), 32'd0);
        chk("wrap_no_ovf", 32'(bus.w_overflow), 32'd0);
        chk("wrap_final_addr", 32'(bus.w_addr), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
